// File: rtl/delay_pipe.sv
// delay_pipe: shift-register delay line with a runtime-selectable output tap.
// Define DELAY_PIPE_FILL_CNT_EN to add the fill_cnt and primed ports.
module delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32,
  parameter int TAPW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic [TAPW-1:0]  tap_sel,
  output logic [WIDTH-1:0] out_data,
`ifdef DELAY_PIPE_FILL_CNT_EN
  output logic [TAPW-1:0]  fill_cnt,
  output logic             primed,
`endif
  output logic             out_valid
);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [TAPW-1:0]             eff;
  logic [IW-1:0]               idx;
  always_comb begin
    eff     = (tap_sel == '0) ? TAPW'(1) : (tap_sel > TAPW'(DEPTH)) ? TAPW'(DEPTH) : tap_sel;
    idx     = IW'(eff - TAPW'(1));
    data_d  = flush ? '0 : in_valid ? {data_q[DEPTH-2:0], in_data} : data_q;
    valid_d = flush ? '0 : in_valid ? {valid_q[DEPTH-2:0], 1'b1} : valid_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  assign out_data  = data_q[idx];
  assign out_valid = valid_q[idx];
`ifdef DELAY_PIPE_FILL_CNT_EN
  logic [TAPW-1:0] fill_q, fill_d;
  // Saturates at DEPTH: beyond that every tap is already primed.
  always_comb
    fill_d = flush ? '0 : (in_valid && fill_q != TAPW'(DEPTH)) ? fill_q + TAPW'(1) : fill_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) fill_q <= '0;
    else        fill_q <= fill_d;
  assign fill_cnt = fill_q;
  assign primed   = fill_q >= eff;
`endif
endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe: directed self-checking bench for delay_pipe (WIDTH=8, DEPTH=32).
module tb_delay_pipe;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       flush = 1'b0;
  logic [5:0] tap_sel = 6'd32;
  logic [7:0] out_data;
  logic       out_valid;
`ifdef DELAY_PIPE_FILL_CNT_EN
  logic [5:0] fill_cnt;
  logic       primed;
`endif
  int n_vec = 0;
  int n_err = 0;

  delay_pipe #(.WIDTH(8), .DEPTH(32), .TAPW(6)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .flush(flush),
    .tap_sel(tap_sel),
    .out_data(out_data),
`ifdef DELAY_PIPE_FILL_CNT_EN
    .fill_cnt(fill_cnt),
    .primed(primed),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2;
    chk("rst_data", 32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
`ifdef DELAY_PIPE_FILL_CNT_EN
    chk("rst_fill", 32'(fill_cnt), 0);
    chk("rst_primed", 32'(primed), 0);
`endif
    #1 reset = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'(i);
      step();
      chk("stream_valid", 32'(out_valid), 32'((i + 1) >= 32));
      chk("stream_data", 32'(out_data), (i + 1) >= 32 ? 32'(i - 31) : 0);
`ifdef DELAY_PIPE_FILL_CNT_EN
      chk("stream_fill", 32'(fill_cnt), (i + 1) >= 32 ? 32 : 32'(i + 1));
`endif
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (5) begin
      step();
      chk("stall_data", 32'(out_data), 8);
      chk("stall_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b1;
    for (int i = 40; i < 45; i++) begin
      in_data = 8'(i);
      step();
      chk("resume_data", 32'(out_data), 32'(i - 31));
    end
    in_valid = 1'b0;
    tap_sel = 6'd0;  #1 chk("tap0", 32'(out_data), 44);
    tap_sel = 6'd1;  #1 chk("tap1", 32'(out_data), 44);
    tap_sel = 6'd40; #1 chk("tap40", 32'(out_data), 13);
    chk("tap40_valid", 32'(out_valid), 1);
    tap_sel = 6'd32; #1 chk("tap32", 32'(out_data), 13);
    tap_sel = 6'd4;  #1 chk("tap4", 32'(out_data), 41);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tap_sel = 6'd1;  #1 chk("flush_data", 32'(out_data), 0);
    chk("flush_valid", 32'(out_valid), 0);
    tap_sel = 6'd32; #1 chk("flush_valid32", 32'(out_valid), 0);
`ifdef DELAY_PIPE_FILL_CNT_EN
    chk("flush_fill", 32'(fill_cnt), 0);
`endif
    tap_sel = 6'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(8'h10 + i);
      step();
      chk("prime_valid", 32'(out_valid), 32'((i + 1) >= 4));
      chk("prime_data", 32'(out_data), (i + 1) >= 4 ? 32'(8'h10 + i - 3) : 0);
`ifdef DELAY_PIPE_FILL_CNT_EN
      chk("prime_fill", 32'(fill_cnt), 32'(i + 1));
      chk("primed", 32'(primed), 32'((i + 1) >= 4));
`endif
    end
    flush = 1'b1; in_data = 8'hAA;
    step();
    flush = 1'b0;
`ifdef DELAY_PIPE_FILL_CNT_EN
    chk("flush2_fill", 32'(fill_cnt), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h20 + i);
      step();
      chk("refill_valid", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    tap_sel = 6'd1; #1 chk("refill_t1", 32'(out_data), 32'h22);
    tap_sel = 6'd3; #1 chk("refill_t3", 32'(out_data), 32'h20);
    chk("refill_t3_valid", 32'(out_valid), 1);
    tap_sel = 6'd4; #1 chk("no_aa_valid", 32'(out_valid), 0);
    chk("no_aa_data", 32'(out_data), 0);
    tap_sel = 6'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h30 + i);
      step();
    end
    chk("pre_rst_data", 32'(out_data), 32'h39);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1 chk("arst_data", 32'(out_data), 0);
    chk("arst_valid", 32'(out_valid), 0);
`ifdef DELAY_PIPE_FILL_CNT_EN
    chk("arst_fill", 32'(fill_cnt), 0);
    chk("arst_primed", 32'(primed), 0);
`endif
    #1 reset = 1'b1;
    #1 chk("rel_valid", 32'(out_valid), 0);
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'h5A);
    chk("post_rst_valid", 32'(out_valid), 1);
    tap_sel = 6'd2; #1 chk("post_rst_t2", 32'(out_valid), 0);
`ifdef DELAY_PIPE_FILL_CNT_EN
    chk("post_rst_fill", 32'(fill_cnt), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
